rob_retire_ctrl: RTL and testbench

Retire-side consumer of the reorder buffer's commit stream. Each cycle it takes the ROB head outputs and performs the architectural side effects: register-file writeback with load extension, and buffered in-order store commit to data memory. It also runs the trap/mret sequence: ROB flush, mepc/mcause update, store drain, then fetch redirect. Sits between the ROB commit port and the register file, data memory and fetch PC mux.

---
 rtl/rob_retire_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rob_retire_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire_ctrl.sv
// rob_retire_ctrl: ROB commit consumer doing regfile writeback, in-order store queue drain and trap/mret sequencing.
// Optional RETIRE_LOAD_EXT_EN enables load sign/zero extension on writeback.
module rob_retire_ctrl #(
    parameter int          SQ_DEPTH    = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rob_value,
    input  logic [4:0]  rob_dest,
    input  logic        rob_reg_write,
    input  logic [31:0] rob_addr,
    input  logic        rob_mem_write,
    input  logic        rob_mem_read,
    input  logic [2:0]  rob_funct3,
    input  logic        rob_exception,
    input  logic        rob_mret,
    input  logic [1:0]  rob_cause,
    input  logic [31:0] rob_epc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    output logic        sq_full,
    output logic        sq_overflow,
    output logic        rob_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] retired_count
);
    localparam int PW = $clog2(SQ_DEPTH);

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN, REDIRECT} state_t;

    state_t      r_state;
    logic [29:0] r_q_addr [SQ_DEPTH];
    logic [31:0] r_q_data [SQ_DEPTH];
    logic [3:0]  r_q_be   [SQ_DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0] r_cnt;
    logic        r_trap;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic        r_ovf;
    logic        r_flush;
    logic        r_redir;
    logic [31:0] r_redir_pc;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_ret;

    logic        w_idle, w_full, w_push, w_push_ok, w_pop;
    logic [31:0] w_wdata, w_st_data;
    logic [3:0]  w_st_be;

    assign w_idle    = r_state == IDLE;
    assign w_full    = r_cnt == (PW+1)'(SQ_DEPTH);
    assign w_push    = w_idle & rob_mem_write;
    assign w_push_ok = w_push & ~w_full;
    assign w_pop     = (r_cnt != '0) & dmem_ack;

    assign w_st_be   = rob_funct3[1:0] == 2'b00 ? 4'b0001 << rob_addr[1:0] :
                       rob_funct3[1:0] == 2'b01 ? (rob_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_st_data = rob_funct3[1:0] == 2'b00 ? {4{rob_value[7:0]}} :
                       rob_funct3[1:0] == 2'b01 ? {2{rob_value[15:0]}} : rob_value;

`ifdef RETIRE_LOAD_EXT_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    assign w_byte = rob_value[{rob_addr[1:0], 3'b000} +: 8];
    assign w_half = rob_addr[1] ? rob_value[31:16] : rob_value[15:0];
    always_comb begin
        w_load = rob_funct3 == 3'b000 ? {{24{w_byte[7]}}, w_byte} :
                 rob_funct3 == 3'b100 ? {24'b0, w_byte} :
                 rob_funct3 == 3'b001 ? {{16{w_half[15]}}, w_half} :
                 rob_funct3 == 3'b101 ? {16'b0, w_half} : rob_value;
    end
    assign w_wdata = rob_mem_read ? w_load : rob_value;
`else
    logic w_unused;
    assign w_unused = rob_funct3[2];
    assign w_wdata  = rob_value;
`endif

    // Queue payload needs no reset; occupancy is tracked by r_cnt.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_q_addr[r_wp] <= rob_addr[31:2];
            r_q_data[r_wp] <= w_st_data;
            r_q_be[r_wp]   <= w_st_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_trap     <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_ovf      <= 1'b0;
            r_flush    <= 1'b0;
            r_redir    <= 1'b0;
            r_redir_pc <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_ret      <= '0;
        end else begin
            r_rf_we    <= w_idle & rob_reg_write & (rob_dest != 5'd0) & ~rob_exception;
            r_rf_waddr <= rob_dest;
            r_rf_wdata <= w_wdata;
            if (w_push_ok) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (PW+1)'(w_push_ok) - (PW+1)'(w_pop);
            if (w_push && w_full) r_ovf <= 1'b1;
            if (w_idle && (rob_reg_write | rob_mem_write | rob_mem_read | rob_exception | rob_mret))
                r_ret <= r_ret + 32'd1;
            r_flush <= 1'b0;
            r_redir <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rob_exception) begin
                        r_mepc   <= rob_epc;
                        r_mcause <= rob_cause == 2'b01 ? 32'd24 : rob_cause == 2'b11 ? 32'd4 : 32'd2;
                        r_trap   <= 1'b1;
                        r_flush  <= 1'b1;
                        r_state  <= FLUSH;
                    end else if (rob_mret) begin
                        r_trap  <= 1'b0;
                        r_flush <= 1'b1;
                        r_state <= FLUSH;
                    end
                end
                FLUSH: r_state <= DRAIN;
                DRAIN: begin
                    if (r_cnt == '0) begin
                        r_redir    <= 1'b1;
                        r_redir_pc <= r_trap ? MTVEC_RESET : r_mepc;
                        r_state    <= REDIRECT;
                    end
                end
                REDIRECT: r_state <= IDLE;
            endcase
        end
    end

    assign rf_we          = r_rf_we;
    assign rf_waddr       = r_rf_waddr;
    assign rf_wdata       = r_rf_wdata;
    assign dmem_req       = r_cnt != '0;
    assign dmem_addr      = {r_q_addr[r_rp], 2'b00};
    assign dmem_wdata     = r_q_data[r_rp];
    assign dmem_be        = r_q_be[r_rp];
    assign sq_full        = r_cnt >= (PW+1)'(SQ_DEPTH - 1);
    assign sq_overflow    = r_ovf;
    assign rob_flush      = r_flush;
    assign redirect_valid = r_redir;
    assign redirect_pc    = r_redir_pc;
    assign mepc           = r_mepc;
    assign mcause         = r_mcause;
    assign retired_count  = r_ret;
endmodule

// File: tb/tb_rob_retire_ctrl.sv
// tb_rob_retire_ctrl: table-driven writeback vectors plus scoreboarded store drain and trap/mret sequences.
module tb_rob_retire_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rob_value, rob_addr, rob_epc;
    logic [4:0]  rob_dest;
    logic        rob_reg_write, rob_mem_write, rob_mem_read, rob_exception, rob_mret;
    logic [2:0]  rob_funct3;
    logic [1:0]  rob_cause;
    logic        rf_we, dmem_req, dmem_ack, sq_full, sq_overflow, rob_flush, redirect_valid;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, dmem_addr, dmem_wdata, redirect_pc, mepc, mcause, retired_count;
    logic [3:0]  dmem_be;

    always #5 clk = ~clk;

    rob_retire_ctrl #(.SQ_DEPTH(4), .MTVEC_RESET(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .rob_value(rob_value), .rob_dest(rob_dest), .rob_reg_write(rob_reg_write),
        .rob_addr(rob_addr), .rob_mem_write(rob_mem_write), .rob_mem_read(rob_mem_read),
        .rob_funct3(rob_funct3), .rob_exception(rob_exception), .rob_mret(rob_mret),
        .rob_cause(rob_cause), .rob_epc(rob_epc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .sq_full(sq_full), .sq_overflow(sq_overflow), .rob_flush(rob_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mepc(mepc), .mcause(mcause), .retired_count(retired_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } st_t;

    typedef struct {
        logic        rw;
        logic        mr;
        logic [4:0]  dest;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] value;
        logic [31:0] ext;
        logic        we;
    } wb_t;

    int          checks = 0;
    int          errors = 0;
    st_t         exp_q[$];
    wb_t         tbl[11];
    logic [31:0] exp_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: the store scoreboard is checked mid-cycle, while ack is stable.
    task automatic tick();
        st_t e;
        @(negedge clk);
        if (dmem_req && dmem_ack) begin
            if (exp_q.size() == 0) chk("dmem_unexpected_req", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("dmem_addr", dmem_addr, e.addr);
                chk("dmem_wdata", dmem_wdata, e.data);
                chk("dmem_be", 32'(dmem_be), 32'(e.be));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        rob_value = '0; rob_addr = '0; rob_epc = '0; rob_dest = '0;
        rob_reg_write = 0; rob_mem_write = 0; rob_mem_read = 0;
        rob_exception = 0; rob_mret = 0; rob_funct3 = '0; rob_cause = '0;
    endtask

    task automatic push_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v,
                           input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] eb,
                           input bit keep);
        rob_mem_write = 1; rob_funct3 = f3; rob_addr = a; rob_value = v;
        if (keep) exp_q.push_back('{ea, ed, eb});
        tick();
        rob_mem_write = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_w;
        int n;
        tbl[0]  = '{1'b1, 1'b0, 5'd5,  3'b010, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 5'd6,  3'b000, 32'h0000_1003, 32'h80AA_BBCC, 32'hFFFF_FF80, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 5'd7,  3'b100, 32'h0000_1003, 32'h80AA_BBCC, 32'h0000_0080, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 5'd8,  3'b001, 32'h0000_1002, 32'h8001_1234, 32'hFFFF_8001, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 5'd9,  3'b101, 32'h0000_1002, 32'h8001_1234, 32'h0000_8001, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 5'd10, 3'b001, 32'h0000_1000, 32'h0000_F00F, 32'hFFFF_F00F, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 5'd11, 3'b000, 32'h0000_1001, 32'h0000_7F00, 32'h0000_007F, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 5'd12, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 5'd0,  3'b010, 32'h0000_0000, 32'h1111_1111, 32'h1111_1111, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 5'd13, 3'b010, 32'h0000_0000, 32'h2222_2222, 32'h2222_2222, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 5'd14, 3'b000, 32'h0000_1000, 32'h0000_00FF, 32'hFFFF_FFFF, 1'b0};

        clr_in();
        dmem_ack = 0;
        rst = 1;
        tick();
        tick();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_sq_full", sq_full, 0);
        chk("rst_sq_overflow", sq_overflow, 0);
        chk("rst_rob_flush", rob_flush, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_mepc", mepc, 0);
        chk("rst_mcause", mcause, 0);
        chk("rst_retired", retired_count, 0);
        rst = 0;
        exp_ret = 0;

        for (int i = 0; i < 11; i++) begin
            rob_reg_write = tbl[i].rw; rob_mem_read = tbl[i].mr; rob_dest = tbl[i].dest;
            rob_funct3 = tbl[i].f3; rob_addr = tbl[i].addr; rob_value = tbl[i].value;
            tick();
            exp_ret += 32'(tbl[i].rw | tbl[i].mr);
`ifdef RETIRE_LOAD_EXT_EN
            exp_w = tbl[i].ext;
`else
            exp_w = tbl[i].value;
`endif
            chk($sformatf("wb_we[%0d]", i), rf_we, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("wb_waddr[%0d]", i), rf_waddr, tbl[i].dest);
                chk($sformatf("wb_wdata[%0d]", i), rf_wdata, exp_w);
            end
            chk($sformatf("wb_retired[%0d]", i), retired_count, exp_ret);
        end
        clr_in();
        tick();
        chk("wb_we_drop", rf_we, 0);

        // Single SB held off three cycles, then accepted.
        push_st(3'b000, 32'h0000_2002, 32'h1234_56AB, 32'h0000_2000, 32'hABAB_ABAB, 4'b0100, 1);
        exp_ret += 1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("sb_req[%0d]", c), dmem_req, 1);
            dmem_ack = (c == 3);
            tick();
        end
        dmem_ack = 0;
        chk("sb_req_done", dmem_req, 0);

        // Fill the queue with ack low, then overflow it.
        push_st(3'b010, 32'h0000_3000, 32'hCAFE_F00D, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111, 1);
        chk("full_after1", sq_full, 0);
        push_st(3'b001, 32'h0000_3007, 32'h1234_5678, 32'h0000_3004, 32'h5678_5678, 4'b1100, 1);
        chk("full_after2", sq_full, 0);
        push_st(3'b000, 32'h0000_3001, 32'h0000_00CD, 32'h0000_3000, 32'hCDCD_CDCD, 4'b0010, 1);
        chk("full_after3", sq_full, 1);
        push_st(3'b010, 32'h0000_300C, 32'h0BAD_BEEF, 32'h0000_300C, 32'h0BAD_BEEF, 4'b1111, 1);
        chk("full_after4", sq_full, 1);
        chk("ovf_before", sq_overflow, 0);
        push_st(3'b010, 32'h0000_3010, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'b0000, 0);
        chk("ovf_after", sq_overflow, 1);
        exp_ret += 5;
        chk("fill_retired", retired_count, exp_ret);
        dmem_ack = 1;
        n = 0;
        while (dmem_req && n < 20) begin tick(); n++; end
        dmem_ack = 0;
        chk("fill_drained", dmem_req, 0);
        chk("fill_sb_empty", exp_q.size(), 0);
        chk("ovf_sticky", sq_overflow, 1);

        // Trap with two stores pending; retire inputs during the sequence are ignored.
        push_st(3'b010, 32'h0000_4000, 32'h1111_1111, 32'h0000_4000, 32'h1111_1111, 4'b1111, 1);
        push_st(3'b010, 32'h0000_4004, 32'h2222_2222, 32'h0000_4004, 32'h2222_2222, 4'b1111, 1);
        rob_exception = 1; rob_cause = 2'b01; rob_epc = 32'h40;
        tick();
        exp_ret += 3;
        clr_in();
        chk("trap_flush", rob_flush, 1);
        chk("trap_mcause", mcause, 24);
        chk("trap_mepc", mepc, 32'h40);
        chk("trap_no_redirect", redirect_valid, 0);
        rob_reg_write = 1; rob_dest = 5'd7; rob_mem_write = 1; rob_addr = 32'h5000; rob_value = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("trap_hold_we[%0d]", c), rf_we, 0);
            chk($sformatf("trap_hold_redir[%0d]", c), redirect_valid, 0);
            chk($sformatf("trap_hold_flush[%0d]", c), rob_flush, 0);
        end
        clr_in();
        dmem_ack = 1;
        n = 0;
        while (!redirect_valid && n < 20) begin tick(); n++; end
        chk("trap_redirect_seen", redirect_valid, 1);
        chk("trap_drained_first", exp_q.size(), 0);
        chk("trap_redirect_pc", redirect_pc, 32'h100);
        chk("trap_retired", retired_count, exp_ret);
        dmem_ack = 0;
        tick();
        chk("trap_redirect_pulse", redirect_valid, 0);

        // mret with an empty queue: flush at +1, redirect at +3.
        rob_mret = 1;
        tick();
        exp_ret += 1;
        clr_in();
        chk("mret_flush", rob_flush, 1);
        chk("mret_mepc", mepc, 32'h40);
        chk("mret_mcause", mcause, 24);
        tick();
        chk("mret_flush_pulse", rob_flush, 0);
        chk("mret_redir_early", redirect_valid, 0);
        tick();
        chk("mret_redirect", redirect_valid, 1);
        chk("mret_redirect_pc", redirect_pc, 32'h40);
        tick();
        chk("mret_redirect_pulse", redirect_valid, 0);

        // Exception beats mret; cause 11 is load-misaligned.
        rob_exception = 1; rob_mret = 1; rob_cause = 2'b11; rob_epc = 32'h80;
        tick();
        exp_ret += 1;
        clr_in();
        chk("mis_mcause", mcause, 4);
        chk("mis_mepc", mepc, 32'h80);
        tick();
        tick();
        chk("mis_redirect", redirect_valid, 1);
        chk("mis_redirect_pc", redirect_pc, 32'h100);
        tick();
        rob_exception = 1; rob_cause = 2'b10; rob_epc = 32'h84;
        tick();
        exp_ret += 1;
        clr_in();
        chk("ill_mcause", mcause, 2);
        chk("ill_mepc", mepc, 32'h84);
        tick();
        tick();
        tick();
        chk("ill_retired", retired_count, exp_ret);

        // Reset while stores are pending discards them.
        push_st(3'b010, 32'h0000_7000, 32'h7777_7777, 32'h0, 32'h0, 4'b0000, 0);
        push_st(3'b010, 32'h0000_7004, 32'h8888_8888, 32'h0, 32'h0, 4'b0000, 0);
        chk("pre_rst_req", dmem_req, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid_req", dmem_req, 0);
        chk("rst_mid_ovf", sq_overflow, 0);
        chk("rst_mid_retired", retired_count, 0);
        dmem_ack = 1;
        push_st(3'b010, 32'h0000_6000, 32'h600D_F00D, 32'h0000_6000, 32'h600D_F00D, 4'b1111, 1);
        chk("post_rst_req", dmem_req, 1);
        tick();
        dmem_ack = 0;
        chk("post_rst_drained", dmem_req, 0);
        chk("post_rst_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
